logical_left_shift_core: RTL and testbench



---
 rtl/logical_left_shift_core.sv | 130 +++++++++++++
 tb/tb_logical_left_shift_core.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/logical_left_shift_core.sv
// Registered logical left shifter: barrel stages plus running overflow flag.
// Ports: clk, rst_n, in_valid, A, B -> out, overflow, out_valid. LLS_PIPE2_EN adds a mid-pipe stage.
module logical_left_shift_core #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic             out_valid
);

  localparam int LG = $clog2(WIDTH);
  localparam int LO = LG / 2;
  localparam int HW = WIDTH - LO;
  localparam logic [WIDTH-1:0] ONES = '1;

  logic [WIDTH-1:0] lo_res;
  logic             lo_ovf;

  always_comb begin
    lo_res = A;
    lo_ovf = 1'b0;
    for (int k = 0; k < LO; k++) begin
      if (B[k]) begin
        lo_ovf = lo_ovf | (|(lo_res & ~(ONES >> (1 << k))));
        lo_res = lo_res << (1 << k);
      end
    end
  end

  logic [WIDTH-1:0] s_res;
  logic             s_ovf;
  logic [HW-1:0]    s_b;
  logic             s_vld;

`ifdef LLS_PIPE2_EN
  logic [WIDTH-1:0] p_res_q, p_res_d;
  logic             p_ovf_q, p_ovf_d;
  logic [HW-1:0]    p_b_q, p_b_d;
  logic             p_vld_q, p_vld_d;

  always_comb begin
    p_res_d = lo_res;
    p_ovf_d = lo_ovf;
    p_b_d   = B[WIDTH-1:LO];
    p_vld_d = in_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_res_q <= '0;
      p_ovf_q <= 1'b0;
      p_b_q   <= '0;
      p_vld_q <= 1'b0;
    end else begin
      p_res_q <= p_res_d;
      p_ovf_q <= p_ovf_d;
      p_b_q   <= p_b_d;
      p_vld_q <= p_vld_d;
    end
  end

  assign s_res = p_res_q;
  assign s_ovf = p_ovf_q;
  assign s_b   = p_b_q;
  assign s_vld = p_vld_q;
`else
  assign s_res = lo_res;
  assign s_ovf = lo_ovf;
  assign s_b   = B[WIDTH-1:LO];
  assign s_vld = in_valid;
`endif

  logic [WIDTH-1:0] hi_res;
  logic             hi_ovf;
  logic             oor;

  // Out of range: everything moves out, so overflow is just "any 1 left",
  // which equals the discarded bits so far OR the surviving partial.
  always_comb begin
    hi_res = s_res;
    hi_ovf = s_ovf;
    for (int k = LO; k < LG; k++) begin
      if (s_b[k-LO]) begin
        hi_ovf = hi_ovf | (|(hi_res & ~(ONES >> (1 << k))));
        hi_res = hi_res << (1 << k);
      end
    end
    oor = |s_b[HW-1:LG-LO];
    if (oor) begin
      hi_ovf = s_ovf | (|s_res);
      hi_res = '0;
    end
  end

  logic [WIDTH-1:0] out_q, out_d;
  logic             ovf_q, ovf_d;
  logic             vld_q, vld_d;

  always_comb begin
    out_d = out_q;
    ovf_d = ovf_q;
    vld_d = s_vld;
    if (s_vld) begin
      out_d = hi_res;
      ovf_d = hi_ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      ovf_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      out_q <= out_d;
      ovf_q <= ovf_d;
      vld_q <= vld_d;
    end
  end

  assign out       = out_q;
  assign overflow  = ovf_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_logical_left_shift_core.sv
// Testbench for logical_left_shift_core: directed and random ops vs a reference model.
// Honors LLS_PIPE2_EN for the expected latency.
module tb_logical_left_shift_core;

`ifdef LLS_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic [15:0] out;
  logic        overflow;
  logic        out_valid;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        v;
    logic [15:0] o;
    logic        f;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] last_o = '0;
  logic        last_f = 1'b0;

  logical_left_shift_core #(.WIDTH(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .A(A),
    .B(B),
    .out(out),
    .overflow(overflow),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: arithmetic on a 32-bit widening of A.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    logic [31:0] full;
    e.v = 1'b1;
    if (b >= 16) begin
      e.o = 16'h0;
      e.f = (a != 0);
    end else begin
      full = {16'h0, a} << b;
      e.o = full[15:0];
      e.f = (full[31:16] != 0);
    end
    return e;
  endfunction

  task automatic step(input string tag, input logic v,
                      input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    exp_t g;
    in_valid = v;
    A = a;
    B = b;
    e = model(a, b);
    e.v = v;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() >= LAT) begin
      g = exp_q.pop_front();
      if (g.v) begin
        last_o = g.o;
        last_f = g.f;
      end
      chk({tag, ".vld"}, {31'b0, out_valid}, {31'b0, g.v});
    end else begin
      chk({tag, ".vld"}, {31'b0, out_valid}, 32'd0);
    end
    chk({tag, ".out"}, {16'b0, out}, {16'b0, last_o});
    chk({tag, ".ovf"}, {31'b0, overflow}, {31'b0, last_f});
  endtask

  task automatic drain();
    for (int i = 0; i < LAT; i++) step("drain", 1'b0, 16'h0, 16'h0);
  endtask

  initial begin
    #2;
    chk("rst.out", {16'b0, out}, 32'd0);
    chk("rst.ovf", {31'b0, overflow}, 32'd0);
    chk("rst.vld", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) step("sweep", 1'b1, 16'h0002, 16'(i));
    drain();

    step("d8001", 1'b1, 16'h8001, 16'd1);
    step("d7fff", 1'b1, 16'h7FFF, 16'd1);
    step("dffff", 1'b1, 16'hFFFF, 16'd16);
    step("d0000", 1'b1, 16'h0000, 16'h0100);
    step("d1234", 1'b1, 16'h1234, 16'd0);
    drain();

    step("tog1", 1'b1, 16'h00F3, 16'd4);
    step("tog0", 1'b0, 16'hFFFF, 16'd3);
    step("tog1b", 1'b1, 16'hC001, 16'd2);
    step("tog0b", 1'b0, 16'h0000, 16'd0);
    drain();

    for (int i = 0; i < 300; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0: b = 16'($urandom);
        1: b = 16'($urandom_range(16, 40));
        default: b = 16'($urandom_range(0, 15));
      endcase
      step("rnd", 1'($urandom_range(0, 3) != 0), a, b);
    end

    step("pre_rst", 1'b1, 16'hABCD, 16'd3);
    step("pre_rst2", 1'b1, 16'h1357, 16'd5);
    in_valid = 1'b1;
    A = 16'hFFFF;
    B = 16'd1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.out", {16'b0, out}, 32'd0);
    chk("arst.ovf", {31'b0, overflow}, 32'd0);
    chk("arst.vld", {31'b0, out_valid}, 32'd0);
    exp_q.delete();
    last_o = '0;
    last_f = 1'b0;
    @(posedge clk);
    #1;
    chk("inrst.vld", {31'b0, out_valid}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("post_rst", 1'b0, 16'h0, 16'h0);
    step("first", 1'b1, 16'h0001, 16'd15);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
